// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : 4-bit operation codes driven on md_unit.md_op
//   - md_state_e  : sequencing states of md_unit
//   - default latencies for multiply-class and divide-class operations
//   - md_sdiv     : signed 32-bit divide helper returning {remainder, quotient}
// MADD/MADDU codes always exist here; md_unit only honours them when
// MDU_MADD_EN is defined.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Works on magnitudes so that 0x80000000 / -1 yields 0x80000000 with a
    // zero remainder instead of relying on signed-overflow behaviour.
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    function automatic logic [63:0] md_sdiv(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        if (mb == '0) begin
            q = '0;
            r = '0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Executes mult/multu/div/divu and mthi/mtlo. The latency is a counter model:
// the result is computed behaviourally at launch, parked in a pending
// register, and written to HI/LO on the last busy cycle.
//
// Ports:
//   clk     in   1   clock, rising-edge
//   reset   in   1   synchronous active-high reset
//   start   in   1   one-cycle launch pulse for md_op
//   md_op   in   4   operation code (md_pkg::md_op_e)
//   a       in   32  rs operand
//   b       in   32  rt operand
//   busy    out  1   operation in flight; HI/LO not yet updated
//   hi_out  out  32  HI register
//   lo_out  out  32  LO register
//
// Parameters: MULT_CYCLES (mult-class latency), DIV_CYCLES (div-class latency).
// Build option: MDU_MADD_EN enables MADD/MADDU (accumulate into {HI,LO});
// without it those codes behave as MD_NONE.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    md_state_e   r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_pend;
    logic        r_pend_wr;
    logic        r_pend_acc;

    md_state_e   w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_launch_cnt;
    logic        w_launch;
    logic        w_commit;
    logic        w_mthi;
    logic        w_mtlo;
    logic [63:0] w_res;
    logic        w_res_wr;
    logic        w_res_acc;

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [63:0]        w_divs;
    logic [31:0]        w_divu_q;
    logic [31:0]        w_divu_r;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};
    assign w_divs   = md_sdiv(a, b);
    assign w_divu_q = (b == '0) ? '0 : a / b;
    assign w_divu_r = (b == '0) ? '0 : a % b;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_launch_cnt = '0;
        w_launch     = 1'b0;
        w_commit     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        w_res        = '0;
        w_res_wr     = 1'b0;
        w_res_acc    = 1'b0;
        busy         = (r_state == ST_BUSY);

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT: begin
                            w_launch     = 1'b1;
                            w_launch_cnt = MULT_CYCLES;
                            w_res        = w_prod_s;
                            w_res_wr     = 1'b1;
                        end
                        MD_MULTU: begin
                            w_launch     = 1'b1;
                            w_launch_cnt = MULT_CYCLES;
                            w_res        = w_prod_u;
                            w_res_wr     = 1'b1;
                        end
                        // Divide by zero still occupies the unit but never writes.
                        MD_DIV: begin
                            w_launch     = 1'b1;
                            w_launch_cnt = DIV_CYCLES;
                            w_res        = w_divs;
                            w_res_wr     = (b != '0);
                        end
                        MD_DIVU: begin
                            w_launch     = 1'b1;
                            w_launch_cnt = DIV_CYCLES;
                            w_res        = {w_divu_r, w_divu_q};
                            w_res_wr     = (b != '0);
                        end
                        MD_MTHI: w_mthi = 1'b1;
                        MD_MTLO: w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
                        MD_MADD: begin
                            w_launch     = 1'b1;
                            w_launch_cnt = MULT_CYCLES;
                            w_res        = w_prod_s;
                            w_res_wr     = 1'b1;
                            w_res_acc    = 1'b1;
                        end
                        MD_MADDU: begin
                            w_launch     = 1'b1;
                            w_launch_cnt = MULT_CYCLES;
                            w_res        = w_prod_u;
                            w_res_wr     = 1'b1;
                            w_res_acc    = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                if (w_launch) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = w_launch_cnt;
                end
            end
            ST_BUSY: begin
                // start is ignored here; the hazard unit keeps it from happening.
                if (r_cnt == 32'd1) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_pend     <= '0;
            r_pend_wr  <= 1'b0;
            r_pend_acc <= 1'b0;
        end else begin
            if (w_launch) begin
                r_pend     <= w_res;
                r_pend_wr  <= w_res_wr;
                r_pend_acc <= w_res_acc;
            end
            if (w_commit && r_pend_wr) begin
                // Accumulation uses HI/LO as they stand at commit, not at launch.
                if (r_pend_acc) {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                else            {r_hi, r_lo} <= r_pend;
            end
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
